mem_arbiter: RTL and testbench

Sequencer and arbiter between the CPU's instruction-fetch and load/store ports and the unified single-read-port `ram`. Grants one access at a time, drives the ram enables and addresses, returns read data with a valid pulse, and raises a stall to the CPU while a request is outstanding. It also rejects stores to the protected low half of memory, where the ram ignores writes, and reports them as faults.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer between CPU fetch and load/store ports and a single-read-port ram.
// Optional fetch starvation guard: define MEM_ARB_STARVE_EN.
module mem_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  input  logic        d_rd_req,
  input  logic        d_wr_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_fault,
  output logic        cpu_stall,
  output logic [31:0] ram_data_address,
  output logic [31:0] ram_instruction_address,
  output logic [31:0] ram_data_to_write,
  output logic        ram_dm_read_en,
  output logic        ram_dm_write_en,
  input  logic [31:0] ram_instruction_read,
  input  logic [31:0] ram_data_read
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic [1:0] {K_FETCH, K_DREAD, K_DWRITE, K_FAULT} kind_e;

  state_e      state_q;
  kind_e       kind_q, kind_d;
  logic [31:0] addr_q, addr_d, wdata_q;
  logic [31:0] if_hold_q, d_hold_q;
  logic        if_valid_q, d_valid_q, d_fault_q;
  logic        d_req, grant_f, grant_d, starve_hit;

  always_comb begin
    d_req   = d_rd_req | d_wr_req;
    grant_f = if_req & (~d_req | starve_hit);
    grant_d = d_req & ~grant_f;
    kind_d  = K_FETCH;
    addr_d  = if_addr;
    if (grant_d) begin
      addr_d = d_addr;
      // Both strobes at once, or a store into the low half, is rejected.
      if ((d_rd_req & d_wr_req) | (d_wr_req & ~d_addr[11])) kind_d = K_FAULT;
      else if (d_wr_req)                                    kind_d = K_DWRITE;
      else                                                  kind_d = K_DREAD;
    end
  end

`ifdef MEM_ARB_STARVE_EN
  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  logic [CW-1:0] burst_q, burst_d;

  assign starve_hit = (burst_q == CW'(MAX_DATA_BURST));

  always_comb begin
    burst_d = burst_q;
    if (state_q == IDLE) begin
      if (!if_req || grant_f)       burst_d = '0;
      else if (grant_d && !starve_hit) burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) burst_q <= '0;
    else      burst_q <= burst_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      kind_q     <= K_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_hold_q  <= '0;
      d_hold_q   <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_fault_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_fault_q  <= 1'b0;
      case (state_q)
        IDLE: if (if_req | d_req) begin
          state_q <= ISSUE;
          kind_q  <= kind_d;
          addr_q  <= addr_d;
          wdata_q <= d_wdata;
        end
        ISSUE: begin
          state_q    <= RESP;
          if_valid_q <= (kind_q == K_FETCH);
          d_valid_q  <= (kind_q != K_FETCH);
          d_fault_q  <= (kind_q == K_FAULT);
        end
        RESP: begin
          state_q <= IDLE;
          if (kind_q == K_FETCH) if_hold_q <= ram_instruction_read;
          if (kind_q == K_DREAD) d_hold_q  <= ram_data_read;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data passes straight through during its response cycle, then holds.
  assign if_data  = if_valid_q ? ram_instruction_read : if_hold_q;
  assign d_rdata  = (d_valid_q && kind_q == K_DREAD) ? ram_data_read : d_hold_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign d_fault  = d_fault_q;

  assign cpu_stall = (if_req | d_req) & ~(if_valid_q | d_valid_q);

  assign ram_dm_read_en          = (state_q == ISSUE) && (kind_q == K_DREAD);
  assign ram_dm_write_en         = (state_q == ISSUE) && (kind_q == K_DWRITE);
  assign ram_data_address        = addr_q;
  assign ram_instruction_address = addr_q;
  assign ram_data_to_write       = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a behavioural ram and memory/ordering model.
module tb_mem_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_rd_req, d_wr_req;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_data, d_rdata;
  logic        if_valid, d_valid, d_fault, cpu_stall;
  logic [31:0] ram_data_address, ram_instruction_address, ram_data_to_write;
  logic        ram_dm_read_en, ram_dm_write_en;
  logic [31:0] ram_instruction_read, ram_data_read;

  int          cyc = 0;
  int          we_cnt = 0;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] seed;
  logic [31:0] mem [0:4095];
  bit          wr_vld [0:4095];
  logic [31:0] ref_mem [0:4095];
  bit          ref_vld [0:4095];
  logic [31:0] exp_if, exp_d;

  mem_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_fault(d_fault), .cpu_stall(cpu_stall),
    .ram_data_address(ram_data_address), .ram_instruction_address(ram_instruction_address),
    .ram_data_to_write(ram_data_to_write), .ram_dm_read_en(ram_dm_read_en),
    .ram_dm_write_en(ram_dm_write_en), .ram_instruction_read(ram_instruction_read),
    .ram_data_read(ram_data_read)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ram_dm_write_en) we_cnt <= we_cnt + 1;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return seed ^ ({20'h0, a} * 32'h9E3779B1);
  endfunction

  // Ram: registered reads, low half write-protected.
  always @(posedge clk) begin
    if (ram_dm_write_en && ram_data_address[11]) begin
      mem[ram_data_address[11:0]]    <= ram_data_to_write;
      wr_vld[ram_data_address[11:0]] <= 1'b1;
    end
    ram_data_read <= wr_vld[ram_data_address[11:0]] ? mem[ram_data_address[11:0]]
                                                    : init_val(ram_data_address[11:0]);
    ram_instruction_read <= wr_vld[ram_instruction_address[11:0]] ? mem[ram_instruction_address[11:0]]
                                                                  : init_val(ram_instruction_address[11:0]);
  end

  function automatic logic [31:0] ref_rd(input logic [11:0] a);
    return ref_vld[a] ? ref_mem[a] : init_val(a);
  endfunction

  // kind: 0 fetch, 1 load, 2 store, 3 load+store together
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int stalls, output logic [31:0] data,
                        output logic flt, output logic other);
    int t0;
    @(posedge clk); #1;
    t0 = cyc; stalls = 0; lat = -1; data = '0; flt = 1'b0; other = 1'b0;
    if_req   = (kind == 0);
    d_rd_req = (kind == 1 || kind == 3);
    d_wr_req = (kind == 2 || kind == 3);
    if_addr = addr; d_addr = addr; d_wdata = wd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_valid || d_valid) begin
        lat   = cyc - t0;
        data  = (kind == 0) ? if_data : d_rdata;
        flt   = d_fault;
        other = (if_valid && d_valid) || cpu_stall || (kind == 0 ? d_valid : if_valid);
        break;
      end
      if (cpu_stall) stalls++;
    end
    if_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; d_rd_req = 1'b0; d_wr_req = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_comb got=%b exp=1", cpu_stall); end
    if_req = 1'b0; #1;
    n_chk++;
    if ({if_valid, d_valid, d_fault, ram_dm_read_en, ram_dm_write_en, cpu_stall} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=000000",
        {if_valid, d_valid, d_fault, ram_dm_read_en, ram_dm_write_en, cpu_stall});
    end
    n_chk++;
    if (if_data !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", if_data, d_rdata);
    end
    exp_if = '0; exp_d = '0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_fetch();
    int lat, st; logic [31:0] dat; logic flt, oth;
    access(0, 32'h10, 32'h0, lat, st, dat, flt, oth);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL fetch_latency got=%0d exp=2", lat); end
    n_chk++; if (st !== 2) begin n_fail++; $display("FAIL fetch_stall_cycles got=%0d exp=2", st); end
    n_chk++; if (dat !== ref_rd(12'h10)) begin n_fail++; $display("FAIL fetch_data got=%h exp=%h", dat, ref_rd(12'h10)); end
    n_chk++; if (oth !== 1'b0 || flt !== 1'b0) begin n_fail++; $display("FAIL fetch_side got=%b%b exp=00", oth, flt); end
    exp_if = ref_rd(12'h10);
    @(negedge clk);
    n_chk++; if (if_data !== exp_if || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_hold got=%h v=%b exp=%h v=0", if_data, if_valid, exp_if); end
  endtask

  task automatic test_store_load();
    int lat, st, w0; logic [31:0] dat; logic flt, oth;
    w0 = we_cnt;
    access(2, 32'h804, 32'hDEADBEEF, lat, st, dat, flt, oth);
    n_chk++; if (lat !== 2 || flt !== 1'b0 || oth !== 1'b0) begin
      n_fail++; $display("FAIL store_resp got lat=%0d flt=%b oth=%b exp lat=2 flt=0 oth=0", lat, flt, oth); end
    n_chk++; if (dat !== exp_d) begin n_fail++; $display("FAIL store_rdata_held got=%h exp=%h", dat, exp_d); end
    n_chk++; if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL store_we_cycles got=%0d exp=1", we_cnt - w0); end
    ref_mem[12'h804] = 32'hDEADBEEF; ref_vld[12'h804] = 1'b1;
    access(1, 32'h804, 32'h0, lat, st, dat, flt, oth);
    n_chk++; if (dat !== 32'hDEADBEEF || flt !== 1'b0) begin
      n_fail++; $display("FAIL load_after_store got=%h flt=%b exp=deadbeef flt=0", dat, flt); end
    exp_d = dat;
  endtask

  task automatic test_fault();
    int lat, st, w0; logic [31:0] dat; logic flt, oth;
    w0 = we_cnt;
    access(2, 32'h004, 32'h12345678, lat, st, dat, flt, oth);
    n_chk++; if (flt !== 1'b1 || lat !== 2) begin n_fail++; $display("FAIL prot_store_fault got flt=%b lat=%0d exp flt=1 lat=2", flt, lat); end
    n_chk++; if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL prot_store_we got=%0d exp=0", we_cnt - w0); end
    n_chk++; if (dat !== exp_d) begin n_fail++; $display("FAIL prot_store_rdata got=%h exp=%h", dat, exp_d); end
    access(1, 32'h004, 32'h0, lat, st, dat, flt, oth);
    n_chk++; if (dat !== init_val(12'h004) || flt !== 1'b0) begin
      n_fail++; $display("FAIL prot_load got=%h flt=%b exp=%h flt=0", dat, flt, init_val(12'h004)); end
    exp_d = dat;
    w0 = we_cnt;
    access(3, 32'h900, 32'hA5A5A5A5, lat, st, dat, flt, oth);
    n_chk++; if (flt !== 1'b1 || we_cnt - w0 !== 0 || dat !== exp_d) begin
      n_fail++; $display("FAIL rdwr_fault got flt=%b we=%0d d=%h exp flt=1 we=0 d=%h", flt, we_cnt - w0, dat, exp_d); end
  endtask

  task automatic test_random();
    int lat, st, w0, k, kind; logic [31:0] dat, a, wd, exp_dat; logic flt, oth, exp_flt;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      kind = (k < 3) ? 0 : (k < 6) ? 1 : (k < 9) ? 2 : 3;
      a = $urandom;
      a[10:4] = '0;
      wd = $urandom;
      w0 = we_cnt;
      access(kind, a, wd, lat, st, dat, flt, oth);
      exp_flt = (kind == 3) || (kind == 2 && !a[11]);
      exp_dat = (kind == 0 || kind == 1) ? ref_rd(a[11:0]) : exp_d;
      n_chk++; if (lat !== 2 || oth !== 1'b0) begin
        n_fail++; $display("FAIL rnd_timing n=%0d got lat=%0d oth=%b exp lat=2 oth=0", n, lat, oth); end
      n_chk++; if (flt !== exp_flt) begin n_fail++; $display("FAIL rnd_fault n=%0d got=%b exp=%b", n, flt, exp_flt); end
      n_chk++; if (dat !== exp_dat) begin n_fail++; $display("FAIL rnd_data n=%0d kind=%0d got=%h exp=%h", n, kind, dat, exp_dat); end
      n_chk++; if (we_cnt - w0 !== ((kind == 2 && !exp_flt) ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd_we n=%0d got=%0d", n, we_cnt - w0); end
      if (kind == 0) exp_if = exp_dat;
      if (kind == 1) exp_d = exp_dat;
      if (kind == 2 && !exp_flt) begin ref_mem[a[11:0]] = wd; ref_vld[a[11:0]] = 1'b1; end
    end
  endtask

  task automatic test_back_to_back();
    int got[$]; int exp[$]; int n_ld;
    bit starve;
    starve = 1'b0;
`ifdef MEM_ARB_STARVE_EN
    starve = 1'b1;
`endif
    // Expected order: data first, fetch slips in once MAXB data grants have gone by.
    for (int i = 0; i < 6; i++) begin
      if (starve && i == MAXB) exp.push_back(1);
      exp.push_back(0);
    end
    if (exp.size() < 7) exp.push_back(1);
    n_ld = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h20; d_rd_req = 1'b1; d_wr_req = 1'b0; d_addr = 32'h800;
    for (int c = 0; c < 60 && got.size() < 7; c++) begin
      @(negedge clk);
      if (d_valid) begin
        got.push_back(0);
        n_chk++; if (d_rdata !== ref_rd(d_addr[11:0])) begin
          n_fail++; $display("FAIL b2b_load_data ld=%0d got=%h exp=%h", n_ld, d_rdata, ref_rd(d_addr[11:0])); end
        exp_d = ref_rd(d_addr[11:0]);
        n_ld++;
        if (n_ld == 6) d_rd_req = 1'b0; else d_addr = 32'h800 + n_ld;
      end
      if (if_valid) begin
        got.push_back(1);
        n_chk++; if (if_data !== ref_rd(12'h20)) begin n_fail++; $display("FAIL b2b_fetch_data got=%h exp=%h", if_data, ref_rd(12'h20)); end
        exp_if = ref_rd(12'h20);
        if_req = 1'b0;
      end
    end
    if_req = 1'b0; d_rd_req = 1'b0;
    n_chk++; if (got.size() !== 7) begin n_fail++; $display("FAIL b2b_grant_count got=%0d exp=7", got.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < got.size()) begin
        n_chk++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_order slot=%0d got=%0d exp=%0d (1=fetch)", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int lat, st; logic [31:0] dat, pre; logic flt, oth;
    pre = ref_rd(12'h808);
    @(posedge clk); #1;
    d_wr_req = 1'b1; d_addr = 32'h808; d_wdata = ~pre;
    @(posedge clk); #2;
    n_chk++; if (ram_dm_write_en !== 1'b1) begin n_fail++; $display("FAIL midrst_issue_we got=%b exp=1", ram_dm_write_en); end
    rst = 1'b0; #1;
    n_chk++; if (ram_dm_write_en !== 1'b0 || {if_valid, d_valid, d_fault} !== 3'b0) begin
      n_fail++; $display("FAIL midrst_ctrl got we=%b v=%b exp we=0 v=000", ram_dm_write_en, {if_valid, d_valid, d_fault}); end
    n_chk++; if (if_data !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_data got=%h/%h exp=0/0", if_data, d_rdata); end
    exp_if = '0; exp_d = '0;
    d_wr_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    access(1, 32'h808, 32'h0, lat, st, dat, flt, oth);
    n_chk++; if (dat !== pre || flt !== 1'b0 || lat !== 2) begin
      n_fail++; $display("FAIL midrst_mem got=%h flt=%b lat=%0d exp=%h flt=0 lat=2", dat, flt, lat, pre); end
  endtask

  initial begin
    rst = 1'b0;
    seed = $urandom;
    test_reset();
    test_fetch();
    test_store_load();
    test_fault();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
